timing_gen_multi: RTL and testbench
===================================

Name: timing_gen_multi

Overview:
- Parametrised successor to the fixed 800x600 timing generator: produces hcount/vcount, hvis/vvis, de, hsync/vsync plus line/frame start pulses.
- Counter width, default mode and default sync polarity are parameters.
- A new video mode (H/V lengths, sync polarities) is loaded at run time through a valid/ready port and takes effect only at a frame boundary.
- Advance is qualified by a pixel clock enable, so lower pixel rates run from the system clock.
- Sits between the clock/reset block and the pixel pipeline, replacing the fixed generator.

Parameters:
- CW, 16, width of counters and of every cfg length field
- H_VIS, 800, default visible pixels per line
- H_FP, 40, default H front porch
- H_SYNC, 128, default H sync width
- H_BP, 88, default H back porch
- V_VIS, 600, default visible lines
- V_FP, 1, default V front porch
- V_SYNC, 4, default V sync width
- V_BP, 23, default V back porch
- HPOL, 1, default hsync active level
- VPOL, 1, default vsync active level

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- ce  in  1  pixel advance enable
- cfg_valid  in  1  new mode offered
- cfg_ready  out  1  new mode can be accepted
- cfg_h_vis, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CW each  H lengths
- cfg_v_vis, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CW each  V lengths
- cfg_hpol, cfg_vpol  in  1 each  sync active levels
- cfg_err  out  1  one-cycle pulse: offered mode rejected
- cfg_applied  out  1  one-cycle pulse: pending mode became active
- hcount, vcount  out  CW  coordinates of the pixel output on the next advance
- hvis, vvis  out  1  in visible H/V region
- de  out  1  hvis & vvis
- hsync, vsync  out  1  sync at active polarity
- line_start  out  1  one-cycle pulse on H wrap
- frame_start  out  1  one-cycle pulse on H and V wrap

Behaviour:
Interface:
- One clock; reset is synchronous and active-high (clk, rst).

Reset:
- Active mode = parameter defaults; pending mode cleared.
- hcount = vcount = 0; hvis = vvis = de = 1.
- hsync = !HPOL; vsync = !VPOL.
- cfg_ready = 1; cfg_err, cfg_applied, line_start, frame_start = 0.
- rst mid-frame or with a pending mode discards the pending mode and restarts at (0,0) with the defaults.

Counting:
- Advance happens only on cycles with ce = 1. With ce = 0, every output holds, except that the pulse outputs drop to 0.
- H total HT = vis+fp+sync+bp. hcount runs 0..HT-1, then wraps to 0 and advances vcount (0..VT-1, then wraps).
- All outputs are registered and aligned to the registered counts:
  - hvis = (hcount < h_vis).
  - hsync is active for hcount in [h_vis+h_fp, h_vis+h_fp+h_sync-1].
  - vvis and vsync follow the same rule on vcount. vvis/vsync change only on an H-wrap advance.
- line_start = 1 in the cycle after an advance that wrapped H. frame_start additionally requires a V wrap. Neither pulses at reset release.

Config handshake:
- Transfer occurs when cfg_valid & cfg_ready. The fields are checked and registered in that same cycle.
- Reject the offer if any length is 0, or if total > 2^CW (sum computed at CW+2 bits).
  - On reject: cfg_err pulses on the next cycle, nothing is stored, cfg_ready stays 1.
- On accept: the mode becomes pending and cfg_ready = 0 until it is applied.
- Apply point: the advance that wraps both H and V. That same edge:
  - loads the active mode and precomputes endpoints;
  - sets counters to 0 and hvis/vvis to 1;
  - sets hsync/vsync to the new inactive levels;
  - pulses frame_start and cfg_applied together;
  - raises cfg_ready.
- A transfer in the apply cycle itself is impossible (cfg_ready = 0 then).
- A mode never takes effect mid-frame.
- Endpoints (vis-1, vis+fp-1, vis+fp+sync-1, total-1) are held in registers so the compare path contains no adder.

Decomposition:
- Package timing_pkg:
  - default 800x600 constants;
  - mode_t struct (eight CW lengths plus two polarities);
  - endpoint struct;
  - function computing endpoints from a mode_t and validity.
- Sub-module timing_axis, instanced for H and V:
  - inputs: advance, load-endpoints, polarity;
  - outputs: count, vis, sync, wrap.

Test Plan:
- Defaults, ce = 1 for 2 frames:
  - line_start every 1056 clk; frame_start every 663168 clk;
  - hsync high for hcount 840..967; vsync high for vcount 601..604;
  - de low at hcount 800.
- ce toggling 1,0,1,0 in mode 4/1/2/1 x 3/1/1/1:
  - counts change only on ce cycles;
  - line_start every 8 ce-cycles (16 clk); frame_start every 48 ce-cycles.
- Offer mode 4/1/2/1, 3/1/1/1, pol 0/0 at mid-frame (hcount 100, vcount 50):
  - cfg_ready = 0 until the default frame ends;
  - cfg_applied and frame_start coincide;
  - hsync idles at 1 and pulses 0 at hcount 5..6.
- Offer with cfg_h_sync = 0, then a total over 2^CW:
  - cfg_err pulses once per offer; cfg_ready stays 1; timing unchanged.
- Assert rst for 1 cycle mid-line with a pending mode:
  - counts go to 0,0 with default timing; cfg_ready = 1; pending mode is never applied.
- Mode 1/1/1/1 x 1/1/1/1 (minimum):
  - HT = 4; hvis is high only at hcount 0; hsync only at hcount 2; frame_start every 16 advances.

Source files
------------

// File: rtl/timing_gen_multi_pkg.sv
// Shared types, default 800x600 timing and endpoint helpers for the
// parametrised video timing generator.
package timing_pkg;

  // Widest counter the helpers support; narrower CW values zero-extend.
  localparam int unsigned MAX_CW = 32;
  localparam int unsigned SUM_W  = MAX_CW + 2;

  localparam int unsigned DEF_H_VIS  = 800;
  localparam int unsigned DEF_H_FP   = 40;
  localparam int unsigned DEF_H_SYNC = 128;
  localparam int unsigned DEF_H_BP   = 88;
  localparam int unsigned DEF_V_VIS  = 600;
  localparam int unsigned DEF_V_FP   = 1;
  localparam int unsigned DEF_V_SYNC = 4;
  localparam int unsigned DEF_V_BP   = 23;

  typedef logic [MAX_CW-1:0] len_t;
  typedef logic [SUM_W-1:0]  sum_t;

  typedef struct packed {
    len_t h_vis, h_fp, h_sync, h_bp;
    len_t v_vis, v_fp, v_sync, v_bp;
    logic hpol, vpol;
  } mode_t;

  // Last count of each region, so the counters compare without adders.
  typedef struct packed {
    len_t vis_last, fp_last, sync_last, tot_last;
  } axis_ep_t;

  typedef struct packed {
    axis_ep_t h, v;
  } ep_t;

  typedef enum logic {ST_IDLE, ST_PEND} cfg_state_t;

  function automatic axis_ep_t axis_ep(len_t vis, len_t fp, len_t sync, len_t bp);
    axis_ep_t e;
    sum_t s1, s2, s3, s4;
    s1 = sum_t'(vis);
    s2 = s1 + sum_t'(fp);
    s3 = s2 + sum_t'(sync);
    s4 = s3 + sum_t'(bp);
    e.vis_last  = len_t'(s1 - sum_t'(1));
    e.fp_last   = len_t'(s2 - sum_t'(1));
    e.sync_last = len_t'(s3 - sum_t'(1));
    e.tot_last  = len_t'(s4 - sum_t'(1));
    return e;
  endfunction

  function automatic ep_t calc_ep(mode_t m);
    ep_t e;
    e.h = axis_ep(m.h_vis, m.h_fp, m.h_sync, m.h_bp);
    e.v = axis_ep(m.v_vis, m.v_fp, m.v_sync, m.v_bp);
    return e;
  endfunction

  // All lengths non-zero and each total no larger than 2^cw.
  function automatic logic mode_ok(mode_t m, int unsigned cw);
    sum_t ht, vt, lim;
    ht  = sum_t'(m.h_vis) + sum_t'(m.h_fp) + sum_t'(m.h_sync) + sum_t'(m.h_bp);
    vt  = sum_t'(m.v_vis) + sum_t'(m.v_fp) + sum_t'(m.v_sync) + sum_t'(m.v_bp);
    lim = sum_t'(1) << cw;
    return (m.h_vis != '0) && (m.h_fp != '0) && (m.h_sync != '0) && (m.h_bp != '0) &&
           (m.v_vis != '0) && (m.v_fp != '0) && (m.v_sync != '0) && (m.v_bp != '0) &&
           (ht <= lim) && (vt <= lim);
  endfunction

endpackage

// File: rtl/timing_gen_multi_if.sv
// Run-time video mode load port (valid/ready plus result pulses).
interface timing_gen_multi_if #(parameter int unsigned CW = 16);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_h_vis, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [CW-1:0] cfg_v_vis, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic          cfg_hpol, cfg_vpol;
  logic          cfg_err;
  logic          cfg_applied;

  modport master (
    output cfg_valid, cfg_h_vis, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_vis, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
    input  cfg_ready, cfg_err, cfg_applied
  );

  modport slave (
    input  cfg_valid, cfg_h_vis, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_vis, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
    output cfg_ready, cfg_err, cfg_applied
  );
endinterface

// File: rtl/timing_gen_multi_axis.sv
// One timing axis (H or V): counter with registered visible/sync flags.
// rst and load both restart at 0 with the endpoints/polarity on ld_*.
module timing_axis import timing_pkg::*; #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          load,
  input  axis_ep_t      ld_ep,
  input  logic          ld_pol,
  output logic [CW-1:0] count,
  output logic          vis,
  output logic          sync,
  output logic          wrap
);

  axis_ep_t ep_q;
  logic     pol_q;

  assign wrap = adv && (len_t'(count) == ep_q.tot_last);

  // Endpoint and polarity registers for the active mode
  always_ff @(posedge clk) begin
    if (rst || load) begin
      ep_q  <= ld_ep;
      pol_q <= ld_pol;
    end
  end

  // Counter; flags toggle on the count before each region boundary
  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
      vis   <= 1'b1;
      sync  <= ~ld_pol;
    end else if (adv) begin
      if (len_t'(count) == ep_q.tot_last) begin
        count <= '0;
        vis   <= 1'b1;
        sync  <= ~pol_q;
      end else begin
        count <= count + CW'(1);
        if (len_t'(count) == ep_q.vis_last)
          vis <= 1'b0;
        if (len_t'(count) == ep_q.fp_last)
          sync <= pol_q;
        else if (len_t'(count) == ep_q.sync_last)
          sync <= ~pol_q;
      end
    end
  end

endmodule

// File: rtl/timing_gen_multi.sv
// Parametrised video timing generator with run-time mode load applied at
// frame boundaries and a pixel clock enable.
module timing_gen_multi import timing_pkg::*; #(
  parameter int unsigned CW     = 16,
  parameter int unsigned H_VIS  = DEF_H_VIS,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned V_VIS  = DEF_V_VIS,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP,
  parameter bit          HPOL   = 1'b1,
  parameter bit          VPOL   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  timing_gen_multi_if.slave      cfg,
  output logic [CW-1:0]          hcount,
  output logic [CW-1:0]          vcount,
  output logic                   hvis,
  output logic                   vvis,
  output logic                   de,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   line_start,
  output logic                   frame_start
);

  mode_t      def_mode, req_mode;
  ep_t        def_ep, req_ep;
  logic       req_ok, xfer, apply;
  logic       h_wrap, v_wrap;
  cfg_state_t st_q, st_d;
  axis_ep_t   pend_h, pend_v;
  logic       pend_hpol, pend_vpol;
  logic       err_q, applied_q;

  // Default mode and the offered mode, both widened to the package width
  always_comb begin
    def_mode        = '0;
    def_mode.h_vis  = len_t'(H_VIS);
    def_mode.h_fp   = len_t'(H_FP);
    def_mode.h_sync = len_t'(H_SYNC);
    def_mode.h_bp   = len_t'(H_BP);
    def_mode.v_vis  = len_t'(V_VIS);
    def_mode.v_fp   = len_t'(V_FP);
    def_mode.v_sync = len_t'(V_SYNC);
    def_mode.v_bp   = len_t'(V_BP);
    def_mode.hpol   = HPOL;
    def_mode.vpol   = VPOL;
    def_ep          = calc_ep(def_mode);

    req_mode        = '0;
    req_mode.h_vis  = len_t'(cfg.cfg_h_vis);
    req_mode.h_fp   = len_t'(cfg.cfg_h_fp);
    req_mode.h_sync = len_t'(cfg.cfg_h_sync);
    req_mode.h_bp   = len_t'(cfg.cfg_h_bp);
    req_mode.v_vis  = len_t'(cfg.cfg_v_vis);
    req_mode.v_fp   = len_t'(cfg.cfg_v_fp);
    req_mode.v_sync = len_t'(cfg.cfg_v_sync);
    req_mode.v_bp   = len_t'(cfg.cfg_v_bp);
    req_mode.hpol   = cfg.cfg_hpol;
    req_mode.vpol   = cfg.cfg_vpol;
    req_ep          = calc_ep(req_mode);
    req_ok          = mode_ok(req_mode, CW);
  end

  assign xfer  = cfg.cfg_valid && (st_q == ST_IDLE);
  assign apply = h_wrap && v_wrap && (st_q == ST_PEND);

  // Pending-mode state register
  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  // Pending-mode next state: accept a valid offer, release on apply
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: if (xfer && req_ok) st_d = ST_PEND;
      ST_PEND: if (apply)          st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  // Pending endpoints are computed at acceptance and held until apply
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_h    <= '0;
      pend_v    <= '0;
      pend_hpol <= 1'b0;
      pend_vpol <= 1'b0;
    end else if (xfer && req_ok) begin
      pend_h    <= req_ep.h;
      pend_v    <= req_ep.v;
      pend_hpol <= req_mode.hpol;
      pend_vpol <= req_mode.vpol;
    end
  end

  // Handshake result pulses and line/frame start pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= 1'b0;
      applied_q   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      err_q       <= xfer && !req_ok;
      applied_q   <= apply;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

  assign cfg.cfg_ready   = (st_q == ST_IDLE);
  assign cfg.cfg_err     = err_q;
  assign cfg.cfg_applied = applied_q;
  assign de              = hvis && vvis;

  // Reset reloads the defaults through the same path the apply uses
  timing_axis #(.CW(CW)) u_h (
    .clk    (clk),
    .rst    (rst),
    .adv    (ce),
    .load   (apply),
    .ld_ep  (rst ? def_ep.h : pend_h),
    .ld_pol (rst ? def_mode.hpol : pend_hpol),
    .count  (hcount),
    .vis    (hvis),
    .sync   (hsync),
    .wrap   (h_wrap)
  );

  timing_axis #(.CW(CW)) u_v (
    .clk    (clk),
    .rst    (rst),
    .adv    (h_wrap),
    .load   (apply),
    .ld_ep  (rst ? def_ep.v : pend_v),
    .ld_pol (rst ? def_mode.vpol : pend_vpol),
    .count  (vcount),
    .vis    (vvis),
    .sync   (vsync),
    .wrap   (v_wrap)
  );

endmodule

// File: tb/tb_timing_gen_multi.sv
// Directed bench for timing_gen_multi; V defaults are shortened
// (3/1/2/1, VT=7) so whole frames fit in a short run. H keeps 800x600 timing.
module tb_timing_gen_multi;
  import timing_pkg::*;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst, ce;
  logic [CW-1:0] hcount, vcount;
  logic          hvis, vvis, de, hsync, vsync, line_start, frame_start;
  int            checks = 0;
  int            failures = 0;

  timing_gen_multi_if #(.CW(CW)) cfg_bus ();

  timing_gen_multi #(
    .CW(CW), .V_VIS(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .cfg         (cfg_bus.slave),
    .hcount      (hcount),
    .vcount      (vcount),
    .hvis        (hvis),
    .vvis        (vvis),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_line(input int budget, output int n);
    n = 0;
    do begin tick(); n++; end while (!line_start && n < budget);
  endtask

  task automatic wait_frame(input int budget, output int n);
    n = 0;
    do begin tick(); n++; end while (!frame_start && n < budget);
  endtask

  task automatic offer(input logic [CW-1:0] hv, hf, hs, hb, vv, vf, vs, vb,
                       input logic hp, vp);
    cfg_bus.cfg_h_vis  = hv;
    cfg_bus.cfg_h_fp   = hf;
    cfg_bus.cfg_h_sync = hs;
    cfg_bus.cfg_h_bp   = hb;
    cfg_bus.cfg_v_vis  = vv;
    cfg_bus.cfg_v_fp   = vf;
    cfg_bus.cfg_v_sync = vs;
    cfg_bus.cfg_v_bp   = vb;
    cfg_bus.cfg_hpol   = hp;
    cfg_bus.cfg_vpol   = vp;
    cfg_bus.cfg_valid  = 1'b1;
    tick();
    cfg_bus.cfg_valid  = 1'b0;
  endtask

  initial begin
    int n, rdy_hi, bad, app_cnt;
    logic [7:0] hs_pat, hv_pat;
    logic [CW-1:0] prev;
    int ls_q[$];
    int fs_q[$];

    rst = 1'b1;
    ce  = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_h_vis = '0; cfg_bus.cfg_h_fp = '0; cfg_bus.cfg_h_sync = '0; cfg_bus.cfg_h_bp = '0;
    cfg_bus.cfg_v_vis = '0; cfg_bus.cfg_v_fp = '0; cfg_bus.cfg_v_sync = '0; cfg_bus.cfg_v_bp = '0;
    cfg_bus.cfg_hpol = 1'b0; cfg_bus.cfg_vpol = 1'b0;
    ticks(2);

    // Reset state
    chk("rst_hcount", hcount, 0);
    chk("rst_vcount", vcount, 0);
    chk("rst_hvis", hvis, 1);
    chk("rst_vvis", vvis, 1);
    chk("rst_de", de, 1);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_ready", cfg_bus.cfg_ready, 1);
    chk("rst_err", cfg_bus.cfg_err, 0);
    chk("rst_applied", cfg_bus.cfg_applied, 0);
    chk("rst_line_start", line_start, 0);
    chk("rst_frame_start", frame_start, 0);

    // Default H timing, ce held high
    rst = 1'b0;
    ce  = 1'b1;
    ticks(799);
    chk("def_h799", hcount, 799);
    chk("def_de799", de, 1);
    tick();
    chk("def_hvis800", hvis, 0);
    chk("def_de800", de, 0);
    ticks(39);
    chk("def_hsync839", hsync, 0);
    tick();
    chk("def_hsync840", hsync, 1);
    ticks(127);
    chk("def_hsync967", hsync, 1);
    tick();
    chk("def_hsync968", hsync, 0);
    ticks(87);
    chk("def_h1055", hcount, 1055);
    chk("def_ls_before_wrap", line_start, 0);
    tick();
    chk("def_wrap_h", hcount, 0);
    chk("def_wrap_v", vcount, 1);
    chk("def_wrap_ls", line_start, 1);
    chk("def_wrap_fs", frame_start, 0);
    wait_line(2000, n);
    chk("def_line_period", n, 1056);
    chk("def_vvis2", vvis, 1);
    wait_line(2000, n);
    chk("def_vvis3", vvis, 0);
    chk("def_vsync3", vsync, 0);
    wait_line(2000, n);
    chk("def_vsync4", vsync, 1);
    wait_line(2000, n);
    chk("def_vsync5", vsync, 1);
    wait_line(2000, n);
    chk("def_vsync6", vsync, 0);
    wait_line(2000, n);
    chk("def_fs_at_wrap", frame_start, 1);
    chk("def_v0", vcount, 0);
    wait_frame(10000, n);
    chk("def_frame_period", n, 7392);

    // Mid-frame offer of 4/1/2/1 x 3/1/1/1, polarities 0/0
    ticks(2212);
    chk("mid_h", hcount, 100);
    chk("mid_v", vcount, 2);
    offer(16'd4, 16'd1, 16'd2, 16'd1, 16'd3, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0);
    chk("acc_ready", cfg_bus.cfg_ready, 0);
    chk("acc_err", cfg_bus.cfg_err, 0);
    chk("acc_h_continues", hcount, 101);
    n = 0;
    rdy_hi = 0;
    do begin
      tick();
      n++;
      if (!cfg_bus.cfg_applied && cfg_bus.cfg_ready) rdy_hi++;
    end while (!cfg_bus.cfg_applied && n < 10000);
    chk("apply_latency", n, 5179);
    chk("ready_low_while_pending", rdy_hi, 0);
    chk("apply_fs", frame_start, 1);
    chk("apply_h", hcount, 0);
    chk("apply_v", vcount, 0);
    chk("apply_hsync_idle", hsync, 1);
    chk("apply_vsync_idle", vsync, 1);
    chk("apply_ready", cfg_bus.cfg_ready, 1);
    for (int i = 0; i < 8; i++) begin
      hs_pat[i] = hsync;
      hv_pat[i] = hvis;
      tick();
    end
    chk("m1_hsync_pattern", hs_pat, 8'b1001_1111);
    chk("m1_hvis_pattern", hv_pat, 8'b0000_1111);
    chk("m1_applied_once", cfg_bus.cfg_applied, 0);
    chk("m1_v1", vcount, 1);
    wait_line(100, n);
    wait_line(100, n);
    wait_line(100, n);
    chk("m1_v4", vcount, 4);
    chk("m1_vsync4", vsync, 0);
    wait_frame(200, n);
    chk("m1_to_frame", n, 16);

    // ce toggling 1,0,1,0 in the 8x6 mode
    bad = 0;
    for (int i = 0; i < 240; i++) begin
      ce   = (i % 2 == 0);
      prev = hcount;
      tick();
      if (ce && hcount == prev) bad++;
      if (!ce && hcount != prev) bad++;
      if (line_start) ls_q.push_back(i);
      if (frame_start) fs_q.push_back(i);
    end
    chk("ce_hold_advance", bad, 0);
    chk("ce_line_count", ls_q.size(), 15);
    chk("ce_line_gap", (ls_q.size() > 1) ? ls_q[1] - ls_q[0] : -1, 16);
    chk("ce_frame_count", fs_q.size(), 2);
    chk("ce_frame_gap", (fs_q.size() > 1) ? fs_q[1] - fs_q[0] : -1, 96);

    // Rejected offers: zero length, then total above 2^CW
    ce = 1'b1;
    offer(16'd4, 16'd1, 16'd0, 16'd1, 16'd3, 16'd1, 16'd1, 16'd1, 1'b1, 1'b1);
    chk("rej0_err", cfg_bus.cfg_err, 1);
    chk("rej0_ready", cfg_bus.cfg_ready, 1);
    tick();
    chk("rej0_err_once", cfg_bus.cfg_err, 0);
    offer(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd3, 16'd1, 16'd1, 16'd1, 1'b1, 1'b1);
    chk("rejbig_err", cfg_bus.cfg_err, 1);
    chk("rejbig_ready", cfg_bus.cfg_ready, 1);
    tick();
    chk("rejbig_err_once", cfg_bus.cfg_err, 0);
    wait_line(100, n);
    wait_line(100, n);
    chk("rej_timing_unchanged", n, 8);

    // Total exactly 2^CW is accepted; reset mid-line then discards it
    offer(16'd16384, 16'd16384, 16'd16384, 16'd16384, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0);
    chk("max_err", cfg_bus.cfg_err, 0);
    chk("max_pending", cfg_bus.cfg_ready, 0);
    ticks(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_h", hcount, 0);
    chk("rst2_v", vcount, 0);
    chk("rst2_ready", cfg_bus.cfg_ready, 1);
    chk("rst2_hsync", hsync, 0);
    wait_line(2000, n);
    chk("rst2_line_period", n, 1056);
    n = 0;
    app_cnt = 0;
    do begin
      tick();
      n++;
      if (cfg_bus.cfg_applied) app_cnt++;
    end while (!frame_start && n < 10000);
    chk("rst2_frame_rest", n, 6336);
    chk("rst2_never_applied", app_cnt, 0);

    // Minimum mode 1/1/1/1 x 1/1/1/1
    offer(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 1'b1, 1'b1);
    n = 0;
    do begin tick(); n++; end while (!cfg_bus.cfg_applied && n < 10000);
    chk("min_apply_latency", n, 7391);
    for (int i = 0; i < 4; i++) begin
      hs_pat[i] = hsync;
      hv_pat[i] = hvis;
      tick();
    end
    chk("min_hvis_pattern", hv_pat[3:0], 4'b0001);
    chk("min_hsync_pattern", hs_pat[3:0], 4'b0100);
    wait_frame(100, n);
    chk("min_frame_rest", n, 12);
    wait_frame(100, n);
    chk("min_frame_period", n, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
